// File: rtl/ps2_kbd_rx.sv
// Host-side PS/2 keyboard receiver.
// Synchronises the raw PS/2 clock/data pins, removes glitches from the clock,
// and deserialises 11-bit frames (start, D0..D7, odd parity, stop) into a
// byte-wide scan-code stream. Receive only: the PS/2 lines are never driven.
module ps2_kbd_rx #(
  parameter int unsigned FILTER_LEN     = 8,       // 2..255
  parameter int unsigned TIMEOUT_CYCLES = 100000   // mid-frame idle limit
) (
  input  logic       clk,
  input  logic       reset_i,      // asynchronous, active low
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] code_o,
  output logic       strobe_o,
  output logic       err_o,
  output logic       busy_o
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]    FILT_MAX = 8'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Synchroniser stages; bit 1 is the only copy the rest of the logic sees.
  logic [1:0] clk_sync;
  logic [1:0] data_sync;

  // Clock filter state.
  logic [7:0] filt_cnt;
  logic       clk_filt;
  logic       clk_filt_d;
  logic       fall;

  // Frame assembly state.
  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          parity_bit;
  logic [TW-1:0] timer;

  // Two-flop synchronisers for both asynchronous pins; idle level is high.
  // NOTE: every clocked register uses <= so all flops update from pre-edge
  // values; blocking assignments here would collapse the synchroniser chain.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_i};
      data_sync <= {data_sync[0], ps2_data_i};
    end
  end

  // Filtered clock only follows the synchronised clock after it has held a
  // new level for FILTER_LEN consecutive cycles; shorter glitches are lost.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      filt_cnt   <= '0;
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
    end else begin
      clk_filt_d <= clk_filt;
      if (clk_sync[1] != clk_filt) begin
        if (filt_cnt == FILT_MAX) begin
          clk_filt <= clk_sync[1];
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + 8'd1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  // Falling edge of the filtered clock; data is sampled in this same cycle.
  assign fall = clk_filt_d & ~clk_filt;

  // Frame FSM with registered outputs and the mid-frame inactivity timer.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      parity_bit <= 1'b0;
      timer      <= '0;
      code_o     <= '0;
      strobe_o   <= 1'b0;
      err_o      <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      // Pulses default low and are raised only in their event cycle.
      strobe_o <= 1'b0;
      err_o    <= 1'b0;

      if (fall) begin
        unique case (state)
          S_IDLE: begin
            // A high data bit on a falling edge is not a start bit: ignore it.
            if (!data_sync[1]) begin
              state   <= S_DATA;
              bit_cnt <= '0;
              busy_o  <= 1'b1;
            end
          end
          S_DATA: begin
            shreg   <= {data_sync[1], shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= S_PARITY;
            end
          end
          S_PARITY: begin
            parity_bit <= data_sync[1];
            state      <= S_STOP;
          end
          S_STOP: begin
            // Byte is delivered even when parity or stop bit is wrong.
            state    <= S_IDLE;
            busy_o   <= 1'b0;
            code_o   <= shreg;
            strobe_o <= 1'b1;
            err_o    <= ((^shreg ^ parity_bit) != 1'b1) || !data_sync[1];
          end
          default: begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
          end
        endcase
      end

      // Timer runs only mid-frame; a fall always wins over an expiring timer.
      if (state == S_IDLE) begin
        timer <= '0;
      end else if (fall) begin
        timer <= '0;
      end else if (timer == TO_MAX) begin
        state  <= S_IDLE;
        busy_o <= 1'b0;
        err_o  <= 1'b1;
        timer  <= '0;
      end else begin
        timer <= timer + 1'b1;
      end
    end
  end

endmodule
